branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 65 ++++++
 tb/tb_branch_predictor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare direction predictor with a table of saturating counters,
// speculative global history and history repair on misprediction.
module branch_predictor #(
   parameter int IDX_W    = 10,
   parameter int CTR_W    = 2,
   parameter int HIST_W   = 8,
   parameter int MODE     = 1,
   parameter int INIT_CTR = 2**(CTR_W-1)-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              lookup_valid,
   input  logic [31:0]       lookup_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [HIST_W-1:0] pred_hist,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic [HIST_W-1:0] upd_hist,
   input  logic              upd_taken,
   input  logic              upd_mispredict,
   output logic [15:0]       perf_mispred
);
   localparam int DEPTH = 2**IDX_W;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   logic [CTR_W-1:0]  r_tbl [DEPTH];
   logic [HIST_W-1:0] r_ghr;
   logic [IDX_W-1:0]  w_lk_idx, w_up_idx;
   logic [CTR_W-1:0]  w_up_ctr, w_up_nxt;
   logic              w_lk_taken, w_repair;
   logic [HIST_W-1:0] w_ghr_nxt;
   always_comb begin
      w_lk_idx   = lookup_pc[IDX_W+1:2] ^ (MODE == 1 ? IDX_W'(r_ghr) : '0);
      w_up_idx   = upd_pc[IDX_W+1:2] ^ (MODE == 1 ? IDX_W'(upd_hist) : '0);
      w_lk_taken = r_tbl[w_lk_idx][CTR_W-1];
      w_up_ctr   = r_tbl[w_up_idx];
      w_up_nxt   = upd_taken ? (w_up_ctr == CTR_MAX ? w_up_ctr : w_up_ctr + CTR_W'(1))
                             : (w_up_ctr == '0 ? w_up_ctr : w_up_ctr - CTR_W'(1));
      w_repair   = upd_valid && upd_mispredict;
      // a repair wins over the speculative shift of a same-cycle lookup
      w_ghr_nxt  = w_repair     ? (upd_hist << 1) | HIST_W'(upd_taken)
                 : lookup_valid ? (r_ghr << 1) | HIST_W'(w_lk_taken)
                 :                r_ghr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= CTR_W'(INIT_CTR);
         r_ghr        <= '0;
         pred_valid   <= 1'b0;
         pred_taken   <= 1'b0;
         pred_hist    <= '0;
         perf_mispred <= '0;
      end else if (rdy) begin
         if (upd_valid) r_tbl[w_up_idx] <= w_up_nxt;
         r_ghr      <= w_ghr_nxt;
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_taken <= w_lk_taken;
            pred_hist  <= r_ghr;
         end
         if (w_repair && perf_mispred != 16'hFFFF) perf_mispred <= perf_mispred + 16'd1;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: drives a bimodal and a gshare instance with one directed stream and
// checks both against a behavioural model through an expected-result queue.
module tb_branch_predictor;
   logic clk = 0, rst = 1, rdy = 0, lookup_valid = 0, upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
   logic [31:0] lookup_pc = 0, upd_pc = 0;
   logic [7:0] upd_hist = 0;
   logic [1:0] pv_o, tk_o;
   logic [1:0][7:0] h_o;
   logic [1:0][15:0] pf_o;
   int n_run = 0, n_fail = 0;
   typedef struct {bit tk; logic [7:0] h;} exp_t;
   exp_t sbq[$];
   int tbl[2][1024];
   logic [7:0] ghr[2], hh[2];
   bit hv[2], htk[2];
   int perf[2];
   always #5 clk = ~clk;
   branch_predictor #(.MODE(0)) u_bi (
      .clk(clk), .rst(rst), .rdy(rdy), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pv_o[0]), .pred_taken(tk_o[0]), .pred_hist(h_o[0]),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict), .perf_mispred(pf_o[0]));
   branch_predictor #(.MODE(1)) u_gs (
      .clk(clk), .rst(rst), .rdy(rdy), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pv_o[1]), .pred_taken(tk_o[1]), .pred_hist(h_o[1]),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict), .perf_mispred(pf_o[1]));
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1024; i++) tbl[m][i] = 1;
         ghr[m] = 0; hh[m] = 0; hv[m] = 0; htk[m] = 0; perf[m] = 0;
      end
      sbq.delete();
   endtask
   function automatic int idx(int m, logic [31:0] pc, logic [7:0] h);
      return m == 1 ? int'(pc[11:2] ^ {2'b00, h}) : int'(pc[11:2]);
   endfunction
   task automatic check_all(string tag);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s.valid[%0d]", tag, m), 32'(pv_o[m]), 32'(hv[m]));
         chk($sformatf("%s.taken[%0d]", tag, m), 32'(tk_o[m]), 32'(htk[m]));
         chk($sformatf("%s.hist[%0d]", tag, m), 32'(h_o[m]), 32'(hh[m]));
         chk($sformatf("%s.perf[%0d]", tag, m), 32'(pf_o[m]), 32'(perf[m]));
      end
   endtask
   task automatic step(string tag, bit r, bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc,
                       logic [7:0] uh, bit ut, bit um);
      logic [7:0] ng;
      int li, ui;
      exp_t e;
      rdy = r; lookup_valid = lv; lookup_pc = lpc; upd_valid = uv;
      upd_pc = upc; upd_hist = uh; upd_taken = ut; upd_mispredict = um;
      if (r) for (int m = 0; m < 2; m++) begin
         ng = ghr[m];
         hv[m] = lv;
         if (lv) begin
            li = idx(m, lpc, ghr[m]);
            sbq.push_back('{tbl[m][li] >= 2, ghr[m]});
            ng = {ghr[m][6:0], tbl[m][li] >= 2};
         end
         if (uv) begin
            ui = idx(m, upc, uh);
            tbl[m][ui] = ut ? (tbl[m][ui] < 3 ? tbl[m][ui] + 1 : 3) : (tbl[m][ui] > 0 ? tbl[m][ui] - 1 : 0);
            if (um) begin
               ng = {uh[6:0], ut};
               perf[m] = perf[m] < 65535 ? perf[m] + 1 : 65535;
            end
         end
         ghr[m] = ng;
      end
      @(posedge clk);
      #1;
      if (r && lv) for (int m = 0; m < 2; m++) begin
         e = sbq.pop_front();
         htk[m] = e.tk;
         hh[m] = e.h;
      end
      check_all(tag);
   endtask
   initial begin
      model_reset();
      #12;
      check_all("reset");
      rst = 0;
      @(posedge clk);
      #1;
      step("lk100", 1, 1, 32'h100, 0, 0, 0, 0, 0);
      chk("r33.taken", 32'(tk_o[1]), 0);
      chk("r33.hist", 32'(h_o[1]), 0);
      for (int k = 0; k < 3; k++) step("inc200", 1, 0, 0, 1, 32'h200, 8'h00, 1, 0);
      step("lk200t", 1, 1, 32'h200, 0, 0, 0, 0, 0);
      chk("r34.sat_taken", 32'(tk_o[0]), 1);
      for (int k = 0; k < 4; k++) step("dec200", 1, 0, 0, 1, 32'h200, 8'h00, 0, 0);
      step("lk200n", 1, 1, 32'h200, 0, 0, 0, 0, 0);
      chk("r34.sat_nt", 32'(tk_o[0]), 0);
      step("clr_ghr", 1, 0, 0, 1, 32'h300, 8'h00, 0, 1);
      step("mp_ignored", 1, 0, 0, 0, 32'h300, 8'h00, 0, 1);
      step("tr400h0", 1, 0, 0, 1, 32'h400, 8'h00, 1, 0);
      step("tr400h1", 1, 0, 0, 1, 32'h400, 8'h01, 1, 0);
      step("tr400h3", 1, 0, 0, 1, 32'h400, 8'h03, 1, 0);
      step("ghr0", 1, 1, 32'h400, 0, 0, 0, 0, 0);
      chk("r35.h0", 32'(h_o[1]), 32'h00);
      step("ghr1", 1, 1, 32'h400, 0, 0, 0, 0, 0);
      chk("r35.h1", 32'(h_o[1]), 32'h01);
      step("ghr3", 1, 1, 32'h400, 0, 0, 0, 0, 0);
      chk("r35.h3", 32'(h_o[1]), 32'h03);
      chk("r35.taken", 32'(tk_o[1]), 1);
      step("repair", 1, 0, 0, 1, 32'h400, 8'h01, 0, 1);
      step("lk500", 1, 1, 32'h500, 0, 0, 0, 0, 0);
      chk("r35.repaired", 32'(h_o[1]), 32'h02);
      step("clr_ghr2", 1, 0, 0, 1, 32'h700, 8'h00, 0, 1);
      step("collide", 1, 1, 32'h600, 1, 32'h600, 8'h00, 1, 0);
      chk("r36.old_ctr", 32'(tk_o[1]), 0);
      step("after_col", 1, 1, 32'h600, 0, 0, 0, 0, 0);
      chk("r36.new_ctr", 32'(tk_o[1]), 1);
      for (int k = 0; k < 5; k++)
         step("frozen", 0, k[0], 32'h100, ~k[0], 32'h600, 8'h00, 0, 1);
      chk("r37.perf", 32'(pf_o[1]), 32'(perf[1]));
      step("thaw", 1, 1, 32'h600, 0, 0, 0, 0, 0);
      step("pre_rst", 1, 1, 32'h400, 0, 0, 0, 0, 0);
      #2 rst = 1;
      #1;
      model_reset();
      check_all("async_rst");
      #2 rst = 0;
      step("post_rst", 1, 0, 0, 0, 0, 0, 0, 0);
      step("lk400", 1, 1, 32'h400, 0, 0, 0, 0, 0);
      chk("tbl_reset", 32'(tk_o[1]), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
